pwm_peripheral: RTL and testbench

- Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 user outputs.
- Generates one shared 8-bit PWM waveform from a prescaled free-running counter.
- Duty-cycle updates are double-buffered so they only take effect at a period boundary.
- Gates each output bit by its output-enable and PWM-enable bits.

---
 rtl/pwm_pkg.sv | 6 +
 rtl/pwm_tick_gen.sv | 19 +
 rtl/pwm_peripheral.sv | 50 +++++
 tb/tb_pwm_peripheral.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and constants for the PWM peripheral.
package pwm_pkg;
   localparam int PWM_CNT_W = 8;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam int NUM_OUT = 16;
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: free-running prescaler, tick high for one clk every PRESCALE clks.
module pwm_tick_gen #(
   parameter int PRESCALE = 13
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [W-1:0] pre_q, pre_d;
   always_comb begin
      tick  = (pre_q == W'(PRESCALE - 1));
      pre_d = tick ? '0 : pre_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: shared 8-bit PWM with period-aligned duty shadow, gated onto 16 outputs.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         en_reg_out_7_0,
   input  logic [7:0]         en_reg_out_15_8,
   input  logic [7:0]         en_reg_pwm_7_0,
   input  logic [7:0]         en_reg_pwm_15_8,
   input  logic [7:0]         pwm_duty_cycle,
   output logic [NUM_OUT-1:0] out,
   output logic               period_start
);
   logic                 tick, wrap, pwm_lvl, ps_q;
   logic [PWM_CNT_W-1:0] cnt_q, cnt_d, duty_q, duty_d;
   logic [NUM_OUT-1:0]   oe, pe, out_q, out_d;
   pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );
   // The shadow reloads on the same edge cnt wraps, so a period never mixes duties.
   always_comb begin
      wrap    = tick && (cnt_q == '1);
      cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
      duty_d  = wrap ? pwm_duty_cycle : duty_q;
      pwm_lvl = (duty_q == DUTY_FULL) || (cnt_q < duty_q);
      oe      = {en_reg_out_15_8, en_reg_out_7_0};
      pe      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      out_d   = oe & (~pe | {NUM_OUT{pwm_lvl}});
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         duty_q <= '0;
         out_q  <= '0;
         ps_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         out_q  <= out_d;
         ps_q   <= wrap;
      end
   end
   assign out          = out_q;
   assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: PRESCALE=13 and PRESCALE=1 instances against a time-based model plus literal period checks.
module tb_pwm_peripheral;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] oe = '0, pe = '0;
   logic [7:0]  duty = '0;
   logic [15:0] out13, out1;
   logic        ps13, ps1;
   logic        chk_en = 1'b0;
   int          vectors = 0, miscompares = 0;
   int          hc [16];
   int          mn [2];
   logic [7:0]  mduty [2];
   logic [15:0] mout [2];
   logic        mps [2];
   always #5 clk = ~clk;
   pwm_peripheral #(.PRESCALE(13)) dut13 (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (oe[7:0]),
      .en_reg_out_15_8 (oe[15:8]),
      .en_reg_pwm_7_0  (pe[7:0]),
      .en_reg_pwm_15_8 (pe[15:8]),
      .pwm_duty_cycle  (duty),
      .out             (out13),
      .period_start    (ps13)
   );
   pwm_peripheral #(.PRESCALE(1)) dut1 (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (oe[7:0]),
      .en_reg_out_15_8 (oe[15:8]),
      .en_reg_pwm_7_0  (pe[7:0]),
      .en_reg_pwm_15_8 (pe[15:8]),
      .pwm_duty_cycle  (duty),
      .out             (out1),
      .period_start    (ps1)
   );
   function automatic int pval(input int j);
      return (j == 1) ? 1 : 13;
   endfunction
   // Level from elapsed time: counter step is n/P, period phase is that mod 256.
   function automatic logic lvl(input int n, input logic [7:0] d, input int p);
      return (d == 8'd255) || (((n / p) % 256) < int'(d));
   endfunction
   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (rst) begin
            mn[j]    <= 0;
            mduty[j] <= '0;
            mout[j]  <= '0;
            mps[j]   <= 1'b0;
         end else begin
            mout[j] <= oe & (~pe | {16{lvl(mn[j], mduty[j], pval(j))}});
            mn[j]   <= mn[j] + 1;
            mps[j]  <= ((mn[j] + 1) % (256 * pval(j))) == 0;
            if (((mn[j] + 1) % (256 * pval(j))) == 0) mduty[j] <= duty;
         end
      end
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (chk_en) begin
         check("out13_model", {16'h0, out13}, {16'h0, mout[0]});
         check("ps13_model", {31'h0, ps13}, {31'h0, mps[0]});
         check("out1_model", {16'h0, out1}, {16'h0, mout[1]});
         check("ps1_model", {31'h0, ps1}, {31'h0, mps[1]});
      end
   end
   // Counts each bit's high cycles over one period: the cycle after a period_start up to the next one.
   task automatic measure(input logic p1, input logic wait_first, output int len);
      int guard;
      if (wait_first) begin
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!(p1 ? ps1 : ps13) && guard < 5000);
         if (guard >= 5000) check("wait_period_start", 32'd0, 32'd1);
      end
      for (int i = 0; i < 16; i++) hc[i] = 0;
      len = 0;
      do begin
         @(negedge clk);
         len++;
         for (int i = 0; i < 16; i++) hc[i] += int'(p1 ? out1[i] : out13[i]);
      end while (!(p1 ? ps1 : ps13) && len < 5000);
   endtask
   initial begin
      int len;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_out13", {16'h0, out13}, 32'h0);
      check("rst_ps13", {31'h0, ps13}, 32'h0);
      check("rst_out1", {16'h0, out1}, 32'h0);
      rst = 1'b0;
      oe  = 16'hFFFF;
      @(negedge clk);
      check("static_high", {16'h0, out13}, 32'hFFFF);
      rst = 1'b1;
      @(negedge clk);
      check("rst_again_out13", {16'h0, out13}, 32'h0);
      check("rst_again_out1", {16'h0, out1}, 32'h0);
      rst  = 1'b0;
      oe   = 16'h0001;
      pe   = 16'h0001;
      duty = 8'd128;
      measure(1'b0, 1'b1, len);
      check("p128_len", len, 3328);
      check("p128_high", hc[0], 1664);
      duty = 8'd0;
      measure(1'b0, 1'b0, len);
      check("p128_kept_high", hc[0], 1664);
      duty = 8'd255;
      measure(1'b0, 1'b0, len);
      check("p0_high", hc[0], 0);
      measure(1'b0, 1'b0, len);
      check("p255_high", hc[0], 3328);
      duty = 8'd64;
      measure(1'b0, 1'b0, len);
      check("p255_again_high", hc[0], 3328);
      fork
         measure(1'b0, 1'b0, len);
         begin
            repeat (1300) @(negedge clk);
            duty = 8'd192;
         end
      join
      check("p64_midchange_high", hc[0], 832);
      measure(1'b0, 1'b0, len);
      check("p192_high", hc[0], 2496);
      check("p192_len", len, 3328);
      oe   = 16'hFF00;
      pe   = 16'hF000;
      duty = 8'd64;
      measure(1'b0, 1'b0, len);
      check("mix_b12_old_duty", hc[12], 2496);
      check("mix_b8_static", hc[8], 3328);
      check("mix_b0_off", hc[0], 0);
      measure(1'b0, 1'b0, len);
      check("mix_b15_pwm", hc[15], 832);
      check("mix_b11_static", hc[11], 3328);
      check("mix_b7_off", hc[7], 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      oe   = 16'h0001;
      pe   = 16'h0001;
      duty = 8'd0;
      measure(1'b1, 1'b1, len);
      check("p1_len", len, 256);
      check("p1_first_high", hc[0], 0);
      duty = 8'd10;
      repeat (255) @(negedge clk);
      duty = 8'd100;
      @(negedge clk);
      check("p1_wrap_pulse", {31'h0, ps1}, 32'h1);
      measure(1'b1, 1'b0, len);
      check("p1_wrap_duty_high", hc[0], 100);
      check("p1_len2", len, 256);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
